// File: rtl/fsm_0_pkg.sv
// rtl/fsm_0_pkg.sv - shared types and constants for fsm_0 and its stimulus sequencer
package fsm_0_pkg;

  localparam int FSM0_W  = 8;
  localparam int FSM0_DW = 8;
  localparam logic [FSM0_W-1:0] FSM0_IDLE_CODE = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/fsm_0_state_seq_if.sv
// rtl/fsm_0_state_seq_if.sv - host write channel carrying {state code, dwell} entries
interface fsm_0_state_seq_if #(
  parameter int W  = 8,
  parameter int DW = 8
);
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_state;
  logic [DW-1:0] wr_dwell;

  modport master (output wr_valid, output wr_state, output wr_dwell, input wr_ready);
  modport slave  (input wr_valid, input wr_state, input wr_dwell, output wr_ready);
endinterface

// File: rtl/seq_fifo.sv
// rtl/seq_fifo.sv - synchronous FIFO with flush; the extra level bit separates full from empty
module seq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  // flush wins over both ports so a write racing an abort is dropped
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fsm_0_state_seq.sv
// rtl/fsm_0_state_seq.sv - plays queued state codes onto fsm_0.in_val, each held dwell+1 cycles
module fsm_0_state_seq
  import fsm_0_pkg::*;
#(
  parameter int             W         = FSM0_W,
  parameter int             DW        = FSM0_DW,
  parameter int             DEPTH     = 4,
  parameter logic [W-1:0]   IDLE_CODE = W'(FSM0_IDLE_CODE)
) (
  input  logic                   clk,
  input  logic                   rstn,
  fsm_0_state_seq_if.slave       wr_if,
  input  logic                   start,
  input  logic                   abort,
  output logic [W-1:0]           state_out,
  output logic                   state_vld,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
);
  localparam int EW = W + DW;

  seq_state_e     state;
  logic [DW-1:0]  cnt;
  logic [EW-1:0]  head;
  logic [W-1:0]   head_code;
  logic [DW-1:0]  head_dwell;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;

  assign head_code  = head[EW-1:DW];
  assign head_dwell = head[DW-1:0];
  assign wr_if.wr_ready = !fifo_full;

  // Pop exactly when the FSM consumes the head below; abort flushes instead.
  always_comb begin
    pop = 1'b0;
    if (!abort && !fifo_empty) begin
      if (state == S_IDLE && start)                pop = 1'b1;
      else if (state == S_RUN && cnt == '0)        pop = 1'b1;
    end
  end

  seq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_if.wr_valid),
    .wdata ({wr_if.wr_state, wr_if.wr_dwell}),
    .pop   (pop),
    .rdata (head),
    .flush (abort),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      state_out <= IDLE_CODE;
      state_vld <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      state_out <= IDLE_CODE;
      state_vld <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !fifo_empty) begin
            state_out <= head_code;
            cnt       <= head_dwell;
            state_vld <= 1'b1;
            busy      <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - DW'(1);
          end else if (!fifo_empty) begin
            state_out <= head_code;
            cnt       <= head_dwell;
          end else begin
            state_out <= IDLE_CODE;
            state_vld <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_0_state_seq.sv
// tb/tb_fsm_0_state_seq.sv - directed self-checking bench for fsm_0_state_seq
module tb_fsm_0_state_seq;
  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       abort;
  logic [7:0] state_out;
  logic       state_vld;
  logic       busy;
  logic       done;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done_base;

  fsm_0_state_seq_if #(.W(8), .DW(8)) wr_if ();

  fsm_0_state_seq #(.W(8), .DW(8), .DEPTH(4), .IDLE_CODE(8'h00)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_if     (wr_if),
    .start     (start),
    .abort     (abort),
    .state_out (state_out),
    .state_vld (state_vld),
    .busy      (busy),
    .done      (done),
    .level     (level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] code, input logic [7:0] dwell);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_state = code;
    wr_if.wr_dwell = dwell;
    step();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [7:0] exp1 [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h00};
  logic [7:0] exp4 [6] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'h00};
  logic [7:0] exp5 [3] = '{8'h44, 8'h44, 8'h00};

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_state = '0;
    wr_if.wr_dwell = '0;
    step();
    step();
    rstn = 1'b1;
    step();
    check_eq("rst_state_out", state_out, 8'h00);
    check_eq("rst_vld", state_vld, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_wr_ready", wr_if.wr_ready, 1);

    // basic playback
    push(8'h11, 8'd0);
    push(8'h22, 8'd2);
    push(8'h33, 8'd1);
    check_eq("s1_level", level, 3);
    done_base = done_cnt;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("s1_code%0d", i), state_out, exp1[i]);
      check_eq($sformatf("s1_vld%0d", i), state_vld, (i < 6) ? 1 : 0);
      check_eq($sformatf("s1_busy%0d", i), busy, 1);
      check_eq($sformatf("s1_done%0d", i), done, (i == 6) ? 1 : 0);
      step();
    end
    check_eq("s1_busy_end", busy, 0);
    check_eq("s1_done_end", done, 0);
    check_eq("s1_done_count", done_cnt - done_base, 1);

    // fill beyond DEPTH
    for (int i = 0; i < 5; i++) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_state = 8'(8'h60 + i);
      wr_if.wr_dwell = 8'd0;
      check_eq($sformatf("s2_ready%0d", i), wr_if.wr_ready, (i < 4) ? 1 : 0);
      step();
    end
    wr_if.wr_valid = 1'b0;
    check_eq("s2_level_full", level, 4);
    check_eq("s2_ready_full", wr_if.wr_ready, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("s2_level_flushed", level, 0);
    check_eq("s2_ready_flushed", wr_if.wr_ready, 1);

    // start with empty FIFO
    done_base = done_cnt;
    pulse_start();
    check_eq("s3_busy", busy, 0);
    check_eq("s3_state_out", state_out, 8'h00);
    step();
    step();
    check_eq("s3_busy_late", busy, 0);
    check_eq("s3_no_done", done_cnt - done_base, 0);

    // write extends a running sequence
    push(8'hA5, 8'd3);
    done_base = done_cnt;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("s4_code%0d", i), state_out, exp4[i]);
      if (i == 1) begin
        wr_if.wr_valid = 1'b1;
        wr_if.wr_state = 8'h5A;
        wr_if.wr_dwell = 8'd0;
      end
      step();
      wr_if.wr_valid = 1'b0;
    end
    check_eq("s4_busy_end", busy, 0);
    check_eq("s4_done_count", done_cnt - done_base, 1);

    // abort mid-run, with a write in the abort cycle
    push(8'h11, 8'd5);
    push(8'h22, 8'd0);
    push(8'h33, 8'd0);
    done_base = done_cnt;
    pulse_start();
    check_eq("s5_first", state_out, 8'h11);
    step();
    abort = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_state = 8'h99;
    wr_if.wr_dwell = 8'd0;
    step();
    abort = 1'b0;
    wr_if.wr_valid = 1'b0;
    check_eq("s5_state_out", state_out, 8'h00);
    check_eq("s5_vld", state_vld, 0);
    check_eq("s5_busy", busy, 0);
    check_eq("s5_level", level, 0);
    step();
    step();
    check_eq("s5_no_done", done_cnt - done_base, 0);
    push(8'h44, 8'd1);
    done_base = done_cnt;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("s5_replay%0d", i), state_out, exp5[i]);
      step();
    end
    check_eq("s5_replay_done", done_cnt - done_base, 1);

    // asynchronous reset mid-run
    push(8'h55, 8'd4);
    push(8'h66, 8'd0);
    done_base = done_cnt;
    pulse_start();
    step();
    check_eq("s6_running", state_out, 8'h55);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("s6_rst_state_out", state_out, 8'h00);
    check_eq("s6_rst_vld", state_vld, 0);
    check_eq("s6_rst_busy", busy, 0);
    check_eq("s6_rst_done", done, 0);
    check_eq("s6_rst_level", level, 0);
    rstn = 1'b1;
    step();
    check_eq("s6_ready", wr_if.wr_ready, 1);
    check_eq("s6_level", level, 0);
    check_eq("s6_busy", busy, 0);
    check_eq("s6_no_done", done_cnt - done_base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_0_state_seq.md
# fsm_0_state_seq

Upstream stimulus sequencer for `fsm_0`. A host loads {state code, dwell} pairs into a small FIFO. On `start`, the block plays the codes out on `state_out`, which drives `fsm_0.in_val`. Each code is held for a programmed number of cycles, codes follow back-to-back, and `done` pulses when the list is exhausted.

## Interface
- `W`, 8, state code width; matches `fsm_0.in_val`.
- `DW`, 8, dwell counter width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `IDLE_CODE`, 8'h00, value driven on `state_out` when not sequencing.

- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `wr_valid`  in  1  host offers an entry.
- `wr_ready`  out  1  `!full`; entry accepted when `wr_valid && wr_ready`.
- `wr_state`  in  W  state code of the offered entry.
- `wr_dwell`  in  DW  extra hold cycles for that code.
- `start`  in  1  begin playback; sampled only in IDLE.
- `abort`  in  1  stop and flush; highest priority.
- `state_out`  out  W  registered code to `fsm_0.in_val`.
- `state_vld`  out  1  high while `state_out` carries a FIFO code.
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse at normal end of sequence.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Reset values: `state_out`=IDLE_CODE, `state_vld`=0, `busy`=0, `done`=0, `level`=0, `wr_ready`=1. FSM goes to IDLE and the FIFO is emptied.
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start` && !empty: pop head, `state_out`←code, `cnt`←dwell, go to RUN.
  - `start` while empty is ignored, and no `done` is produced.
- **RUN**
  - If `cnt`≠0: `cnt`−1.
  - If `cnt`==0 and !empty: pop the next entry with no gap cycle.
  - If `cnt`==0 and empty: `state_out`←IDLE_CODE, `state_vld`←0, go to DONE.
- **DONE**
  - `done`=1 for this cycle only, then return to IDLE.
- Each code is visible for exactly dwell+1 cycles. Dwell 0 gives 1 cycle.
- `abort`, in any state:
  - flush the FIFO, `state_out`←IDLE_CODE, `state_vld`←0, go to IDLE;
  - no `done` pulse;
  - a write presented in the same cycle is dropped.
- `start` in RUN or DONE is ignored.
- Writes are allowed in every state.
  - A write accepted before the cycle where `cnt`==0 of the last code extends the running sequence.
  - A later write waits for the next `start`.
- FIFO full: `wr_ready`=0 even if a pop occurs in the same cycle. This avoids a combinational ready path.
- Same-cycle push and pop on a non-empty, non-full FIFO: `level` is unchanged.
- Read and write pointers wrap modulo DEPTH. The extra `level` bit distinguishes full from empty.

## Timing
- `start` sampled at edge k: code0 appears on `state_out` from edge k, with `state_vld`=1 and `busy`=1.
- A write accepted at edge k is poppable from edge k+1. A `start` sampled at edge k+1 may use it.
- Last code ends at edge m: `state_out`=IDLE_CODE from edge m, `done`=1 during cycle m…m+1, `busy`=0 from edge m+1.
- Asserting `rstn` mid-sequence forces the reset values immediately. No `done` is produced.

## Structure
- Shared package `fsm_0_pkg`:
  - FSM state enum (IDLE/RUN/DONE);
  - `IDLE_CODE` default;
  - W/DW width constants shared with `fsm_0`.
- Sub-module `seq_fifo`:
  - synchronous FIFO, DEPTH×(W+DW);
  - `push`, `pop`, `flush`, `full`, `empty`, `level`;
  - same `clk`/`rstn`.

## Test plan
- Load (8'h11,0),(8'h22,2),(8'h33,1), then `start` → `state_out` reads 11,22,22,22,33,33 on consecutive cycles, then 00. `done` pulses once and `busy` drops the cycle after.
- Write 5 entries back-to-back with DEPTH=4 and no start → entries 1–4 accepted, `wr_ready`=0 on the 5th, `level`=4.
- `start` with the FIFO empty → `busy` stays 0, `done` never pulses, `state_out`=00.
- During RUN of (8'hA5,3), write (8'h5A,0) two cycles in → A5 for 4 cycles, 5A for 1 cycle, single `done`.
- `abort` in the 2nd cycle of (8'h11,5) with 2 entries queued → `state_out`=00 next edge, `level`=0, no `done`. A new load plus `start` then replays normally.
- Drop `rstn` mid-RUN → all outputs at reset values without waiting for a clock. After release, `wr_ready`=1 and `level`=0.
